// File: rtl/binary_mul_3_1_uni.sv
// binary_mul_3_1_uni: four-stage pipelined unsigned multiplier, P = A * B.
// Stage 1 registers the operands. Stage 2 forms the shifted partial products.
// Stage 3 adds all but the top partial product and carries the top one along.
// Stage 4 adds the last term into the registered product P.
// A global enable freezes every stage. rst_n is a synchronous, active-high reset.
// Optional feature: define BINARY_MUL_VALID_EN to add a p_valid output.
// p_valid is driven by a 4-deep valid shift register.
module binary_mul_3_1_uni #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P
`ifdef BINARY_MUL_VALID_EN
  ,
  output logic               p_valid
`endif
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    pp_q [WIDTH];
  logic [PW-1:0]    pp_d [WIDTH];
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    ppTop_q, ppTop_d;
  logic [PW-1:0]    p_q, p_d;

  // Next-state for every stage: hold by default, advance only when enabled
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ppTop_d = ppTop_q;
    p_d     = p_q;
    for (int i = 0; i < WIDTH; i++) begin
      pp_d[i] = pp_q[i];
    end
    if (en) begin
      a_d = A;
      b_d = B;
      for (int i = 0; i < WIDTH; i++) begin
        pp_d[i] = b_q[i] ? (PW'(a_q) << i) : '0;
      end
      sum_d = '0;
      for (int i = 0; i < WIDTH - 1; i++) begin
        sum_d = sum_d + pp_q[i];
      end
      ppTop_d = pp_q[WIDTH-1];
      p_d     = sum_q + ppTop_q;
    end
  end

  // Pipeline registers. Reset takes priority and flushes all in-flight products.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ppTop_q <= '0;
      p_q     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        pp_q[i] <= '0;
      end
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ppTop_q <= ppTop_d;
      p_q     <= p_d;
      for (int i = 0; i < WIDTH; i++) begin
        pp_q[i] <= pp_d[i];
      end
    end
  end

  assign P = p_q;

`ifdef BINARY_MUL_VALID_EN
  logic [3:0] valid_q, valid_d;

  // A 1 enters the valid chain on each enabled edge. It reaches the top after 4 edges.
  always_comb begin
    valid_d = valid_q;
    if (en) begin
      valid_d = {valid_q[2:0], 1'b1};
    end
  end

  // Valid chain register: cleared by reset, frozen while the enable is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign p_valid = valid_q[3];
`endif

endmodule

// File: tb/tb_binary_mul_3_1_uni.sv
// tb_binary_mul_3_1_uni: scoreboard bench for the pipelined 3x3 multiplier.
// Expected products are queued when they are sampled and popped on each enabled edge.
// When p_valid is built (BINARY_MUL_VALID_EN), it is checked on every edge as well.
module tb_binary_mul_3_1_uni;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] A;
  logic [2:0] B;
  logic [5:0] P;
`ifdef BINARY_MUL_VALID_EN
  logic       p_valid;
`endif

  int expQ[$];
  int lastExp;
  int enCount;
  int total;
  int bad;

  binary_mul_3_1_uni #(.WIDTH(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .A      (A),
    .B      (B),
    .P      (P)
`ifdef BINARY_MUL_VALID_EN
    ,
    .p_valid(p_valid)
`endif
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, then check P just after the posedge.
  // Three zeros are queued on reset, because the flushed stages emit 0 before the first new product.
  task automatic applyStimulus(input int a, input int b, input logic e, input logic r);
    int aVal;
    int bVal;
    aVal  = a;
    bVal  = b;
    A     = aVal[2:0];
    B     = bVal[2:0];
    en    = e;
    rst_n = r;
    @(posedge clk);
    #1;
    if (r) begin
      expQ.delete();
      repeat (3) expQ.push_back(0);
      lastExp = 0;
      enCount = 0;
      checkOutput($sformatf("reset P (A=%0d B=%0d)", a, b), int'(P), 0);
    end else if (e) begin
      expQ.push_back(a * b);
      lastExp = expQ.pop_front();
      enCount++;
      checkOutput($sformatf("pipe P (in %0d*%0d, edge %0d)", a, b, enCount), int'(P), lastExp);
    end else begin
      checkOutput($sformatf("stall P (in %0d*%0d)", a, b), int'(P), lastExp);
    end
`ifdef BINARY_MUL_VALID_EN
    checkOutput("p_valid", int'(p_valid), int'(enCount >= 4));
`endif
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    en    = 1'b1;
    A     = 3'd0;
    B     = 3'd0;
    @(negedge clk);

    $display("[TB] reset with 7*7 applied");
    applyStimulus(7, 7, 1'b1, 1'b1);
    applyStimulus(7, 7, 1'b1, 1'b1);
    applyStimulus(7, 7, 1'b1, 1'b0);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        repeat (4) applyStimulus(a, b, 1'b1, 1'b0);
      end
    end

    $display("[TB] back-to-back pairs");
    applyStimulus(2, 3, 1'b1, 1'b0);
    applyStimulus(7, 6, 1'b1, 1'b0);
    applyStimulus(5, 5, 1'b1, 1'b0);
    applyStimulus(1, 7, 1'b1, 1'b0);
    repeat (4) applyStimulus(0, 0, 1'b1, 1'b0);

    $display("[TB] stall with 6*6 in flight");
    applyStimulus(6, 6, 1'b1, 1'b0);
    applyStimulus(3, 5, 1'b1, 1'b0);
    applyStimulus(7, 7, 1'b0, 1'b0);
    applyStimulus(5, 3, 1'b0, 1'b0);
    applyStimulus(4, 7, 1'b0, 1'b0);
    applyStimulus(2, 2, 1'b1, 1'b0);
    applyStimulus(1, 1, 1'b1, 1'b0);
    applyStimulus(0, 0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1'b1, 1'b0);

    $display("[TB] random traffic with occasional stalls");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(int'($urandom_range(7)), int'($urandom_range(7)),
                    logic'($urandom_range(3) != 0), 1'b0);
    end

    $display("[TB] mid-operation reset");
    applyStimulus(7, 7, 1'b1, 1'b0);
    applyStimulus(6, 5, 1'b1, 1'b0);
    applyStimulus(3, 3, 1'b1, 1'b1);
    applyStimulus(5, 7, 1'b1, 1'b0);
    applyStimulus(2, 6, 1'b1, 1'b0);
    applyStimulus(4, 4, 1'b1, 1'b0);
    applyStimulus(1, 3, 1'b1, 1'b0);
    repeat (4) applyStimulus(7, 3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
